// File: rtl/adma_axi_slv_mem.sv
// AXI4 slave SRAM endpoint with independent read and write burst engines.
// Define ADMA_SLV_MEM_STALL_EN to throttle rvalid/wready once per STALL_PERIOD.
module adma_axi_slv_mem #(
  parameter int MST_ID_W = 5,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int LEN_W = 8,
  parameter int RESP_W = 2,
  parameter int MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int STALL_PERIOD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MST_ID_W-1:0] s_arid_i,
  input  logic [ADDR_W-1:0]   s_araddr_i,
  input  logic [LEN_W-1:0]    s_arlen_i,
  input  logic [1:0]          s_arburst_i,
  input  logic                s_arvalid_i,
  output logic                s_arready_o,
  output logic [MST_ID_W-1:0] s_rid_o,
  output logic [DATA_W-1:0]   s_rdata_o,
  output logic [RESP_W-1:0]   s_rresp_o,
  output logic                s_rlast_o,
  output logic                s_rvalid_o,
  input  logic                s_rready_i,
  input  logic [MST_ID_W-1:0] s_awid_i,
  input  logic [ADDR_W-1:0]   s_awaddr_i,
  input  logic [LEN_W-1:0]    s_awlen_i,
  input  logic [1:0]          s_awburst_i,
  input  logic                s_awvalid_i,
  output logic                s_awready_o,
  input  logic [DATA_W-1:0]   s_wdata_i,
  input  logic                s_wlast_i,
  input  logic                s_wvalid_i,
  output logic                s_wready_o,
  output logic [MST_ID_W-1:0] s_bid_o,
  output logic [RESP_W-1:0]   s_bresp_o,
  output logic                s_bvalid_o,
  input  logic                s_bready_i
);

  localparam int BYTES = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_SZ = (ADDR_W+1)'(MEM_DEPTH * BYTES);
  localparam logic [RESP_W-1:0] OKAY = RESP_W'(0);
  localparam logic [RESP_W-1:0] SLVERR = RESP_W'(2);
  localparam logic [RESP_W-1:0] DECERR = RESP_W'(3);
  localparam logic [1:0] B_INCR = 2'b01;

  typedef enum logic {R_IDLE, R_BURST} r_st_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_st_e;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // Below-base addresses underflow to a huge offset, so one compare suffices.
  function automatic logic [RESP_W-1:0] beat_resp(
    input logic [ADDR_W-1:0] a,
    input logic              illegal
  );
    if (illegal) return SLVERR;
    if (({1'b0, a} - WIN_LO) >= WIN_SZ) return DECERR;
    return OKAY;
  endfunction

  function automatic logic [MEM_AW-1:0] widx(input logic [ADDR_W-1:0] a);
    return MEM_AW'((a - BASE_ADDR) >> ADDR_LSB);
  endfunction

  function automatic logic [ADDR_W-1:0] nxt(
    input logic [ADDR_W-1:0] a,
    input logic [1:0]        bt
  );
    return (bt == B_INCR) ? a + ADDR_W'(BYTES) : a;
  endfunction

  function automatic logic [RESP_W-1:0] worst(
    input logic [RESP_W-1:0] a,
    input logic [RESP_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  logic stall;

`ifdef ADMA_SLV_MEM_STALL_EN
  localparam int SCW = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;
  logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
  assign stall = (stall_cnt_q == SCW'(STALL_PERIOD - 1));
  always_comb stall_cnt_d = stall ? '0 : stall_cnt_q + SCW'(1);
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end
`else
  assign stall = 1'b0;
`endif

  r_st_e               r_st_q, r_st_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic [MST_ID_W-1:0] rid_q, rid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [RESP_W-1:0]   rresp_q, rresp_d;
  logic                rlast_q, rlast_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [LEN_W-1:0]    rlen_q, rlen_d;
  logic [1:0]          rbt_q, rbt_d;
  logic [LEN_W-1:0]    rcnt_q, rcnt_d;

  logic                ar_hs, r_hs;
  logic [ADDR_W-1:0]   rd_addr;
  logic [1:0]          rd_bt;
  logic [RESP_W-1:0]   rd_resp;
  logic [DATA_W-1:0]   rd_word;

  assign ar_hs = s_arvalid_i & arready_q;
  assign r_hs  = s_rvalid_o & s_rready_i;

  always_comb begin
    rd_addr = ar_hs ? s_araddr_i : nxt(raddr_q, rbt_q);
    rd_bt   = ar_hs ? s_arburst_i : rbt_q;
    rd_resp = beat_resp(rd_addr, rd_bt[1]);
    rd_word = (rd_resp == OKAY) ? mem[widx(rd_addr)] : '0;
  end

  always_comb begin
    r_st_d    = r_st_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rbt_d     = rbt_q;
    rcnt_d    = rcnt_q;
    unique case (r_st_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          r_st_d    = R_BURST;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rid_d     = s_arid_i;
          raddr_d   = s_araddr_i;
          rlen_d    = s_arlen_i;
          rbt_d     = s_arburst_i;
          rcnt_d    = '0;
          rdata_d   = rd_word;
          rresp_d   = rd_resp;
          rlast_d   = (s_arlen_i == '0);
        end
      end
      R_BURST: begin
        if (r_hs && rlast_q) begin
          r_st_d    = R_IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
        end else if (r_hs) begin
          raddr_d = rd_addr;
          rcnt_d  = rcnt_q + LEN_W'(1);
          rdata_d = rd_word;
          rresp_d = rd_resp;
          rlast_d = ((rcnt_q + LEN_W'(1)) == rlen_q);
        end
      end
      default: r_st_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_q    <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rbt_q     <= '0;
      rcnt_q    <= '0;
    end else begin
      r_st_q    <= r_st_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rbt_q     <= rbt_d;
      rcnt_q    <= rcnt_d;
    end
  end

  w_st_e               w_st_q, w_st_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [MST_ID_W-1:0] bid_q, bid_d;
  logic [RESP_W-1:0]   bresp_q, bresp_d;
  logic [MST_ID_W-1:0] wid_q, wid_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [LEN_W-1:0]    wlen_q, wlen_d;
  logic [1:0]          wbt_q, wbt_d;
  logic [LEN_W-1:0]    wcnt_q, wcnt_d;
  logic [RESP_W-1:0]   werr_q, werr_d;

  logic                aw_hs, w_hs, b_hs, w_final, mem_we;
  logic [RESP_W-1:0]   wr_resp, wacc;

  assign aw_hs   = s_awvalid_i & awready_q;
  assign w_hs    = s_wvalid_i & s_wready_o;
  assign b_hs    = bvalid_q & s_bready_i;
  assign w_final = (wcnt_q == wlen_q);
  assign wr_resp = beat_resp(waddr_q, wbt_q[1]);
  assign mem_we  = w_hs & (wr_resp == OKAY);

  // A misplaced wlast taints the whole burst; the beat count still rules.
  always_comb begin
    wacc = worst(werr_q, wr_resp);
    if (s_wlast_i != w_final) wacc = worst(wacc, SLVERR);
  end

  always_comb begin
    w_st_d    = w_st_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    wid_d     = wid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wbt_d     = wbt_q;
    wcnt_d    = wcnt_q;
    werr_d    = werr_q;
    unique case (w_st_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          w_st_d    = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wid_d     = s_awid_i;
          waddr_d   = s_awaddr_i;
          wlen_d    = s_awlen_i;
          wbt_d     = s_awburst_i;
          wcnt_d    = '0;
          werr_d    = OKAY;
        end
      end
      W_DATA: begin
        if (w_hs && w_final) begin
          w_st_d   = W_RESP;
          wready_d = 1'b0;
          bvalid_d = 1'b1;
          bid_d    = wid_q;
          bresp_d  = wacc;
          werr_d   = wacc;
        end else if (w_hs) begin
          werr_d  = wacc;
          waddr_d = nxt(waddr_q, wbt_q);
          wcnt_d  = wcnt_q + LEN_W'(1);
        end
      end
      W_RESP: begin
        if (b_hs) begin
          w_st_d    = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: w_st_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_st_q    <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
      wid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wbt_q     <= '0;
      wcnt_q    <= '0;
      werr_q    <= '0;
    end else begin
      w_st_q    <= w_st_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      wid_q     <= wid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wbt_q     <= wbt_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[widx(waddr_q)] <= s_wdata_i;
  end

  assign s_arready_o = arready_q;
  assign s_rvalid_o  = rvalid_q & ~stall;
  assign s_rid_o     = rid_q;
  assign s_rdata_o   = rdata_q;
  assign s_rresp_o   = rresp_q;
  assign s_rlast_o   = rlast_q;
  assign s_awready_o = awready_q;
  assign s_wready_o  = wready_q & ~stall;
  assign s_bvalid_o  = bvalid_q;
  assign s_bid_o     = bid_q;
  assign s_bresp_o   = bresp_q;

endmodule

// File: tb/tb_adma_axi_slv_mem.sv
// Directed bench for adma_axi_slv_mem: bursts, backpressure, errors,
// read/write collision and mid-burst reset.
module tb_adma_axi_slv_mem;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   s_arid_i = '0;
  logic [31:0]  s_araddr_i = '0;
  logic [7:0]   s_arlen_i = '0;
  logic [1:0]   s_arburst_i = '0;
  logic         s_arvalid_i = 1'b0;
  logic         s_arready_o;
  logic [4:0]   s_rid_o;
  logic [255:0] s_rdata_o;
  logic [1:0]   s_rresp_o;
  logic         s_rlast_o;
  logic         s_rvalid_o;
  logic         s_rready_i = 1'b0;
  logic [4:0]   s_awid_i = '0;
  logic [31:0]  s_awaddr_i = '0;
  logic [7:0]   s_awlen_i = '0;
  logic [1:0]   s_awburst_i = '0;
  logic         s_awvalid_i = 1'b0;
  logic         s_awready_o;
  logic [255:0] s_wdata_i = '0;
  logic         s_wlast_i = 1'b0;
  logic         s_wvalid_i = 1'b0;
  logic         s_wready_o;
  logic [4:0]   s_bid_o;
  logic [1:0]   s_bresp_o;
  logic         s_bvalid_o;
  logic         s_bready_i = 1'b1;

  always #5 clk = ~clk;

  adma_axi_slv_mem dut (
    .clk(clk), .rst(rst),
    .s_arid_i(s_arid_i), .s_araddr_i(s_araddr_i),
    .s_arlen_i(s_arlen_i), .s_arburst_i(s_arburst_i),
    .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
    .s_rid_o(s_rid_o), .s_rdata_o(s_rdata_o),
    .s_rresp_o(s_rresp_o), .s_rlast_o(s_rlast_o),
    .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .s_awid_i(s_awid_i), .s_awaddr_i(s_awaddr_i),
    .s_awlen_i(s_awlen_i), .s_awburst_i(s_awburst_i),
    .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
    .s_wdata_i(s_wdata_i), .s_wlast_i(s_wlast_i),
    .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
    .s_bid_o(s_bid_o), .s_bresp_o(s_bresp_o),
    .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i)
  );

  localparam logic [1:0] FIX = 2'b00;
  localparam logic [1:0] INC = 2'b01;

  int ncmp = 0;
  int nerr = 0;

  logic [255:0] wd [16];
  logic [255:0] rd_d [16];
  logic [1:0]   rd_r [16];
  logic [4:0]   rd_i [16];
  int           rd_n, rd_lc, rd_li;
  logic [4:0]   bid;
  logic [1:0]   bresp;

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic [15:0] tag, input int i);
    return {16{tag + 16'(i)}};
  endfunction

  task automatic aw_send(input logic [4:0] id, input logic [31:0] a,
                         input logic [7:0] len, input logic [1:0] bt);
    int n;
    s_awid_i = id; s_awaddr_i = a; s_awlen_i = len; s_awburst_i = bt;
    s_awvalid_i = 1'b1;
    n = 0;
    while (!s_awready_o && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("aw_timeout", 256'(n), 256'(0));
    @(negedge clk);
    s_awvalid_i = 1'b0;
  endtask

  task automatic w_send(input int len, input int bad, input int nb);
    int n;
    for (int i = 0; i < nb; i++) begin
      s_wdata_i = wd[i];
      s_wlast_i = (bad < 0) ? (i == len) : (i == bad);
      s_wvalid_i = 1'b1;
      n = 0;
      while (!s_wready_o && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("w_timeout", 256'(n), 256'(0));
      @(negedge clk);
    end
    s_wvalid_i = 1'b0;
    s_wlast_i = 1'b0;
  endtask

  task automatic wr(input logic [4:0] id, input logic [31:0] a,
                    input logic [7:0] len, input logic [1:0] bt,
                    input int bad);
    int n;
    aw_send(id, a, len, bt);
    w_send(int'(len), bad, int'(len) + 1);
    chk("b_latency", 256'(s_bvalid_o), 256'(1));
    n = 0;
    while (!s_bvalid_o && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("b_timeout", 256'(n), 256'(0));
    bid = s_bid_o;
    bresp = s_bresp_o;
    @(negedge clk);
  endtask

  // pat 0: rready always high; pat 1: rready 1,0,0 repeating
  task automatic rd(input logic [4:0] id, input logic [31:0] a,
                    input logic [7:0] len, input logic [1:0] bt,
                    input int pat);
    int n, cyc;
    logic stl, done;
    logic [255:0] hold;
    s_arid_i = id; s_araddr_i = a; s_arlen_i = len; s_arburst_i = bt;
    s_arvalid_i = 1'b1;
    n = 0;
    while (!s_arready_o && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ar_timeout", 256'(n), 256'(0));
    @(negedge clk);
    s_arvalid_i = 1'b0;
    chk("r_latency", 256'(s_rvalid_o), 256'(1));
    rd_n = 0; rd_lc = 0; rd_li = -1;
    cyc = 0; stl = 1'b0; done = 1'b0; hold = '0;
    while (!done && cyc < 200) begin
      s_rready_i = (pat == 0) ? 1'b1 : (cyc % 3 == 0);
      if (stl) chk("r_hold", s_rdata_o, hold);
      if (s_rvalid_o && s_rready_i) begin
        if (rd_n < 16) begin
          rd_d[rd_n] = s_rdata_o;
          rd_r[rd_n] = s_rresp_o;
          rd_i[rd_n] = s_rid_o;
        end
        if (s_rlast_o) begin rd_lc++; rd_li = rd_n; done = 1'b1; end
        rd_n++;
        stl = 1'b0;
      end else if (s_rvalid_o) begin
        stl = 1'b1;
        hold = s_rdata_o;
      end
      @(negedge clk);
      cyc++;
    end
    if (!done) chk("r_timeout", 256'(cyc), 256'(0));
    s_rready_i = 1'b0;
    chk("r_idle_after", 256'(s_rvalid_o), 256'(0));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_arready", 256'(s_arready_o), 256'(0));
    chk("rst_awready", 256'(s_awready_o), 256'(0));
    chk("rst_rvalid", 256'(s_rvalid_o), 256'(0));
    chk("rst_wready", 256'(s_wready_o), 256'(0));
    chk("rst_bvalid", 256'(s_bvalid_o), 256'(0));
    chk("rst_rdata", s_rdata_o, 256'(0));
    chk("rst_rid_bid", 256'({s_rid_o, s_bid_o, s_rresp_o, s_bresp_o,
                             s_rlast_o}), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("arready_up", 256'(s_arready_o), 256'(1));
    chk("awready_up", 256'(s_awready_o), 256'(1));

    // INCR preload and read back
    for (int i = 0; i < 4; i++) wd[i] = mk(16'hA000, i);
    wr(5'd1, 32'h0, 8'd3, INC, -1);
    chk("t1_bid", 256'(bid), 256'(1));
    chk("t1_bresp", 256'(bresp), 256'(0));
    rd(5'd3, 32'h0, 8'd3, INC, 0);
    chk("t1_nbeats", 256'(rd_n), 256'(4));
    chk("t1_rlast", 256'({rd_lc, rd_li}), 256'({32'd1, 32'd3}));
    for (int i = 0; i < 4; i++) begin
      chk("t1_rdata", rd_d[i], mk(16'hA000, i));
      chk("t1_rresp_rid", 256'({rd_r[i], rd_i[i]}), 256'({2'd0, 5'd3}));
    end

    // INCR write at 0x40 lands in words 2 and 3
    wd[0] = mk(16'hD000, 0);
    wd[1] = mk(16'hD000, 1);
    wr(5'd5, 32'h40, 8'd1, INC, -1);
    chk("t2_bid", 256'(bid), 256'(5));
    chk("t2_bresp", 256'(bresp), 256'(0));

    // backpressure read over words 0..3
    rd(5'd4, 32'h0, 8'd3, INC, 1);
    chk("t3_nbeats", 256'(rd_n), 256'(4));
    chk("t3_rlast", 256'({rd_lc, rd_li}), 256'({32'd1, 32'd3}));
    chk("t3_d0", rd_d[0], mk(16'hA000, 0));
    chk("t3_d1", rd_d[1], mk(16'hA000, 1));
    chk("t3_d2", rd_d[2], mk(16'hD000, 0));
    chk("t3_d3", rd_d[3], mk(16'hD000, 1));

    // last word then past end of window
    wd[0] = mk(16'hE000, 0);
    wr(5'd6, 32'd32736, 8'd0, INC, -1);
    chk("t4_top_bresp", 256'(bresp), 256'(0));
    rd(5'd7, 32'd32736, 8'd1, INC, 0);
    chk("t4_top_d0", rd_d[0], mk(16'hE000, 0));
    chk("t4_top_r0", 256'(rd_r[0]), 256'(0));
    chk("t4_top_d1", rd_d[1], 256'(0));
    chk("t4_top_r1", 256'(rd_r[1]), 256'(3));

    // illegal burst type
    wd[0] = mk(16'hFF00, 0);
    wr(5'd8, 32'h0, 8'd0, 2'b10, -1);
    chk("t4_ill_bresp", 256'(bresp), 256'(2));
    rd(5'd9, 32'h0, 8'd0, INC, 0);
    chk("t4_ill_nowrite", rd_d[0], mk(16'hA000, 0));
    rd(5'd9, 32'h0, 8'd0, 2'b11, 0);
    chk("t4_ill_rdata", rd_d[0], 256'(0));
    chk("t4_ill_rresp", 256'(rd_r[0]), 256'(2));

    // wlast early on a 3-beat burst: data written, SLVERR
    for (int i = 0; i < 3; i++) wd[i] = mk(16'hC000, i);
    wr(5'd10, 32'h80, 8'd2, INC, 1);
    chk("t4_wlast_bresp", 256'(bresp), 256'(2));
    chk("t4_wlast_bid", 256'(bid), 256'(10));
    rd(5'd11, 32'h80, 8'd2, INC, 0);
    for (int i = 0; i < 3; i++) chk("t4_wlast_data", rd_d[i], mk(16'hC000, i));

    // write outside window
    wd[0] = mk(16'h1234, 0);
    wr(5'd12, 32'h8000, 8'd0, INC, -1);
    chk("t4_dec_bresp", 256'(bresp), 256'(3));

    // FIXED burst: both beats hit word 6; unaligned read address
    wd[0] = mk(16'hB000, 0);
    wd[1] = mk(16'hB000, 1);
    wr(5'd13, 32'hC0, 8'd1, FIX, -1);
    chk("t_fix_bresp", 256'(bresp), 256'(0));
    rd(5'd14, 32'hC5, 8'd1, FIX, 0);
    chk("t_fix_d0", rd_d[0], mk(16'hB000, 1));
    chk("t_fix_d1", rd_d[1], mk(16'hB000, 1));

    // AR and W beat on word 2 in the same cycle: read sees old data
    aw_send(5'd7, 32'h40, 8'd0, INC);
    s_arid_i = 5'd2; s_araddr_i = 32'h40; s_arlen_i = 8'd0;
    s_arburst_i = INC; s_arvalid_i = 1'b1;
    s_wdata_i = mk(16'h5500, 0); s_wlast_i = 1'b1; s_wvalid_i = 1'b1;
    chk("t5_both_ready", 256'({s_arready_o, s_wready_o}), 256'(2'b11));
    @(negedge clk);
    s_arvalid_i = 1'b0; s_wvalid_i = 1'b0; s_wlast_i = 1'b0;
    chk("t5_rvalid", 256'(s_rvalid_o), 256'(1));
    chk("t5_old_data", s_rdata_o, mk(16'hD000, 0));
    chk("t5_bvalid", 256'(s_bvalid_o), 256'(1));
    chk("t5_bid_bresp", 256'({s_bid_o, s_bresp_o}), 256'({5'd7, 2'd0}));
    s_rready_i = 1'b1;
    @(negedge clk);
    s_rready_i = 1'b0;
    chk("t5_r_done", 256'({s_rvalid_o, s_bvalid_o}), 256'(0));
    rd(5'd2, 32'h40, 8'd0, INC, 0);
    chk("t5_new_data", rd_d[0], mk(16'h5500, 0));

    // reset in the middle of a 4-beat write
    for (int i = 0; i < 4; i++) wd[i] = mk(16'h7700, i);
    aw_send(5'd9, 32'h100, 8'd3, INC);
    w_send(3, -1, 2);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_rst_awready_lo", 256'(s_awready_o), 256'(0));
    chk("t5_rst_wready_lo", 256'(s_wready_o), 256'(0));
    @(negedge clk);
    chk("t5_rst_awready_hi", 256'(s_awready_o), 256'(1));
    begin
      int seen;
      seen = 0;
      repeat (6) begin
        if (s_bvalid_o) seen++;
        @(negedge clk);
      end
      chk("t5_rst_no_b", 256'(seen), 256'(0));
    end
    wd[0] = mk(16'h9900, 0);
    wr(5'd11, 32'h100, 8'd0, INC, -1);
    chk("t5_post_rst_b", 256'({bid, bresp}), 256'({5'd11, 2'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
